// File: rtl/cpu_bus_pkg.sv
// Purpose: shared word type and bus constants for the CPU datapath bus drivers.
// Latency: n/a (declarations only).
// Backpressure: n/a; the bus has no flow control, a driver simply drives or releases.
package cpu_bus_pkg;

  // Native datapath word width.
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Released-bus value for a full datapath word.
  localparam word_t BUS_Z = {WORD_W{1'bz}};

endpackage

// File: rtl/tri_driver.sv
// Purpose: pure combinational tri-state cell, y = en ? d : all-Z.
// Latency: zero; y follows en and d combinationally.
// Backpressure: none; the cell drives whenever en is high.
//
// Ports:
//   en - drive enable, active-high; all bits enable together
//   d  - word to drive
//   y  - tri-state output, all bits Z while en is low
module tri_driver
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output tri   [WIDTH-1:0] y
);

  // One enable for the whole word; there is deliberately no per-bit or
  // per-byte enable, so the bus can never carry a partially driven word.
  assign y = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/buffer_32_32.sv
// Purpose: word-wide tri-state bus driver with drive-state and last-word status.
// Latency: 0 cycles (REGISTERED=0) or 1 cycle for both enable and disable (REGISTERED=1).
// Backpressure: none; the word is placed on the bus whenever selected, contention is
//               left to bus arbitration and observable through driving/last_out.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   IN       - word to place on the bus
//   Sel      - drive enable, active-high
//   OUT      - shared bus output, all bits Z when not driving
//   driving  - high while OUT is actively driven
//   last_out - most recent word actually driven onto OUT
module buffer_32_32
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int REGISTERED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IN,
  input  logic             Sel,
  output tri   [WIDTH-1:0] OUT,
  output logic             driving,
  output logic [WIDTH-1:0] last_out
);

  // Enable and data actually presented to the tri-state cell.
  logic             w_en;
  logic [WIDTH-1:0] w_d;

  logic [WIDTH-1:0] r_last_out;

  generate
    if (REGISTERED != 0) begin : g_reg
      // Drive comes straight from flops so the bus sees no glitches from
      // upstream combinational logic. Reset clears the enable flop, which
      // releases the bus the instant rst_n falls.
      logic             r_sel_q;
      logic [WIDTH-1:0] r_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sel_q  <= 1'b0;
          r_data_q <= '0;
        end else begin
          r_sel_q <= Sel;
          // Only capture a word that is going to be driven; IN wandering
          // while deselected must not disturb the held word.
          if (Sel) begin
            r_data_q <= IN;
          end
        end
      end

      assign w_en = r_sel_q;
      assign w_d  = r_data_q;
    end else begin : g_comb
      // Pass-through: not gated by reset, so the bus follows Sel even while
      // rst_n is low.
      assign w_en = Sel;
      assign w_d  = IN;
    end
  endgenerate

  tri_driver #(
    .WIDTH (WIDTH)
  ) u_tri_driver (
    .en (w_en),
    .d  (w_d),
    .y  (OUT)
  );

  // Record the word that is on the bus at each edge where it is driven.
  // w_d is exactly what the cell is putting on OUT while w_en is high, so
  // sampling it avoids reading back a resolved (possibly contended) bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_out <= '0;
    end else if (w_en) begin
      r_last_out <= w_d;
    end
  end

  assign driving  = w_en;
  assign last_out = r_last_out;

endmodule

// File: tb/tb_buffer_32_32.sv
module tb_buffer_32_32;

  // Both bus nets carry a pull-up, so a released bus resolves to all ones
  // in a 2-state or 4-state simulator alike. Driven test words avoid all-ones.
  localparam logic [31:0] REL = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_c, in_r;
  logic        sel_c, sel_r;
  tri1  [31:0] bus_c, bus_r;
  logic        drv_c, drv_r;
  logic [31:0] last_c, last_r;

  int total;
  int bad;

  buffer_32_32 #(.WIDTH(32), .REGISTERED(0)) u_comb (
    .clk      (clk),
    .rst_n    (rst_n),
    .IN       (in_c),
    .Sel      (sel_c),
    .OUT      (bus_c),
    .driving  (drv_c),
    .last_out (last_c)
  );

  buffer_32_32 #(.WIDTH(32), .REGISTERED(1)) u_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .IN       (in_r),
    .Sel      (sel_r),
    .OUT      (bus_r),
    .driving  (drv_r),
    .last_out (last_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    in_c = 32'h0; sel_c = 1'b0;
    in_r = 32'h0; sel_r = 1'b0;
    #1;
    total++; if (bus_r !== REL) begin bad++; $display("FAIL rst_bus_r got=%h want=%h", bus_r, REL); end
    total++; if (drv_r !== 1'b0) begin bad++; $display("FAIL rst_drv_r got=%b want=0", drv_r); end
    total++; if (last_r !== 32'h0) begin bad++; $display("FAIL rst_last_r got=%h want=0", last_r); end
    total++; if (last_c !== 32'h0) begin bad++; $display("FAIL rst_last_c got=%h want=0", last_c); end
    // Combinational path still follows Sel while in reset; last_out stays 0.
    sel_c = 1'b1; in_c = 32'h0000_1234;
    #1;
    total++; if (bus_c !== 32'h0000_1234) begin bad++; $display("FAIL rst_comb_follow got=%h want=00001234", bus_c); end
    total++; if (drv_c !== 1'b1) begin bad++; $display("FAIL rst_comb_drv got=%b want=1", drv_c); end
    @(posedge clk); #1;
    total++; if (last_c !== 32'h0) begin bad++; $display("FAIL rst_comb_last got=%h want=0", last_c); end
    total++; if (bus_r !== REL) begin bad++; $display("FAIL rst_bus_r_edge got=%h want=%h", bus_r, REL); end
    @(negedge clk);
    sel_c = 1'b0; in_c = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_comb_release();
    @(negedge clk);
    sel_c = 1'b0; in_c = 32'h0;
    #1;
    total++; if (bus_c !== REL) begin bad++; $display("FAIL comb_release_bus got=%h want=%h", bus_c, REL); end
    total++; if (drv_c !== 1'b0) begin bad++; $display("FAIL comb_release_drv got=%b want=0", drv_c); end
  endtask

  task automatic test_comb_pass();
    @(negedge clk);
    sel_c = 1'b1; in_c = 32'h0;
    #1;
    total++; if (bus_c !== 32'h0) begin bad++; $display("FAIL comb_pass0 got=%h want=0", bus_c); end
    total++; if (drv_c !== 1'b1) begin bad++; $display("FAIL comb_pass_drv got=%b want=1", drv_c); end
    in_c = 32'h1;
    #1;
    total++; if (bus_c !== 32'h1) begin bad++; $display("FAIL comb_pass1 got=%h want=1", bus_c); end
    @(posedge clk); #1;
    total++; if (last_c !== 32'h1) begin bad++; $display("FAIL comb_last got=%h want=1", last_c); end
    @(negedge clk);
    sel_c = 1'b0;
  endtask

  task automatic test_reg_enable();
    @(negedge clk);
    sel_r = 1'b1; in_r = 32'hDEAD_BEEF;
    #1;
    total++; if (bus_r !== REL) begin bad++; $display("FAIL reg_pre_edge got=%h want=%h", bus_r, REL); end
    total++; if (drv_r !== 1'b0) begin bad++; $display("FAIL reg_pre_edge_drv got=%b want=0", drv_r); end
    @(posedge clk); #1;
    total++; if (bus_r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reg_drive got=%h want=deadbeef", bus_r); end
    total++; if (drv_r !== 1'b1) begin bad++; $display("FAIL reg_drive_drv got=%b want=1", drv_r); end
    @(negedge clk);
    sel_r = 1'b0; in_r = 32'h0BAD_0BAD;
    #1;
    total++; if (bus_r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reg_hold_until_edge got=%h want=deadbeef", bus_r); end
    @(posedge clk); #1;
    total++; if (bus_r !== REL) begin bad++; $display("FAIL reg_disable got=%h want=%h", bus_r, REL); end
    total++; if (drv_r !== 1'b0) begin bad++; $display("FAIL reg_disable_drv got=%b want=0", drv_r); end
    total++; if (last_r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reg_last got=%h want=deadbeef", last_r); end
  endtask

  task automatic test_reset_mid_drive();
    @(negedge clk);
    sel_r = 1'b1; in_r = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    total++; if (bus_r !== 32'hA5A5_A5A5) begin bad++; $display("FAIL mid_drive got=%h want=a5a5a5a5", bus_r); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus_r !== REL) begin bad++; $display("FAIL mid_rst_bus got=%h want=%h", bus_r, REL); end
    total++; if (drv_r !== 1'b0) begin bad++; $display("FAIL mid_rst_drv got=%b want=0", drv_r); end
    total++; if (last_r !== 32'h0) begin bad++; $display("FAIL mid_rst_last_r got=%h want=0", last_r); end
    total++; if (last_c !== 32'h0) begin bad++; $display("FAIL mid_rst_last_c got=%h want=0", last_c); end
    @(negedge clk);
    rst_n = 1'b1;
    sel_r = 1'b1; in_r = 32'h1357_2468;
    #1;
    total++; if (bus_r !== REL) begin bad++; $display("FAIL post_rst_pre_edge got=%h want=%h", bus_r, REL); end
    @(posedge clk); #1;
    total++; if (bus_r !== 32'h1357_2468) begin bad++; $display("FAIL post_rst_drive got=%h want=13572468", bus_r); end
    total++; if (drv_r !== 1'b1) begin bad++; $display("FAIL post_rst_drv got=%b want=1", drv_r); end
  endtask

  task automatic test_back_to_back();
    logic        sel_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] in_v  [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] exp_v [4] = '{32'd1, REL, 32'd3, REL};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel_r = sel_v[i]; in_r = in_v[i];
      @(posedge clk); #1;
      total++; if (bus_r !== exp_v[i]) begin bad++; $display("FAIL toggle_bus[%0d] got=%h want=%h", i, bus_r, exp_v[i]); end
      total++; if (drv_r !== sel_v[i]) begin bad++; $display("FAIL toggle_drv[%0d] got=%b want=%b", i, drv_r, sel_v[i]); end
    end
    total++; if (last_r !== 32'd3) begin bad++; $display("FAIL toggle_last got=%h want=3", last_r); end
  endtask

  task automatic test_sweep_deselected();
    logic [31:0] sweep [6] = '{32'h0, 32'h1, 32'h55AA_55AA, 32'h8000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sel_c = 1'b0; sel_r = 1'b0;
      in_c = sweep[i]; in_r = sweep[i];
      #1;
      total++; if (bus_c !== REL) begin bad++; $display("FAIL sweep_bus_c[%0d] got=%h want=%h", i, bus_c, REL); end
      total++; if (drv_c !== 1'b0) begin bad++; $display("FAIL sweep_drv_c[%0d] got=%b want=0", i, drv_c); end
      @(posedge clk); #1;
      total++; if (bus_r !== REL) begin bad++; $display("FAIL sweep_bus_r[%0d] got=%h want=%h", i, bus_r, REL); end
      total++; if (drv_r !== 1'b0) begin bad++; $display("FAIL sweep_drv_r[%0d] got=%b want=0", i, drv_r); end
      total++; if (last_r !== 32'd3) begin bad++; $display("FAIL sweep_last_r[%0d] got=%h want=3", i, last_r); end
      total++; if (last_c !== 32'h0) begin bad++; $display("FAIL sweep_last_c[%0d] got=%h want=0", i, last_c); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_comb_release();
    test_comb_pass();
    test_reg_enable();
    test_reset_mid_drive();
    test_back_to_back();
    test_sweep_deselected();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
